// File: rtl/ecc_pkg.sv
// Shared types and helpers for the ECC point datapath blocks.
package ecc_pkg;

    localparam int N_DEFAULT = 231;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MUL_XX,
        ST_ADD_A,
        ST_MUL_TX,
        ST_ADD_B,
        ST_MUL_YY,
        ST_CMP,
        ST_DONE
    } state_t;

    // Operands are zero-extended to N_DEFAULT bits, so callers narrower than that just cast.
    function automatic logic [N_DEFAULT-1:0] mod_add(
        input logic [N_DEFAULT-1:0] u,
        input logic [N_DEFAULT-1:0] v,
        input logic [N_DEFAULT-1:0] m
    );
        logic [N_DEFAULT:0] sum;
        sum = {1'b0, u} + {1'b0, v};
        if (sum >= {1'b0, m}) begin
            sum = sum - {1'b0, m};
        end
        return sum[N_DEFAULT-1:0];
    endfunction

endpackage

// File: rtl/point_on_curve_check_if.sv
// Request/operand/result bundle between a point producer and point_on_curve_check.
interface point_on_curve_check_if #(
    parameter int N = ecc_pkg::N_DEFAULT
);
    logic         start;
    logic [N-1:0] p;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         infinity;
    logic         busy;
    logic         done;
    logic         on_curve;
    logic         range_err;

    modport master (
        output start, p, a, b, x, y, infinity,
        input  busy, done, on_curve, range_err
    );

    modport slave (
        input  start, p, a, b, x, y, infinity,
        output busy, done, on_curve, range_err
    );
endinterface

// File: rtl/mod_mult_serial.sv
// Interleaved MSB-first modular multiplier: r = a*b mod p, one bit of b per cycle.
// rdy is high in the last of the N stepping cycles; r holds the result from the next cycle on.
module mod_mult_serial #(
    parameter int N = ecc_pkg::N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] p,
    output logic [N-1:0] r,
    output logic         rdy
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    dbl;
    logic [N:0]    acc;

    always_comb begin
        r_d   = r_q;
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;

        dbl = {r_q, 1'b0};
        if (dbl >= {1'b0, p}) begin
            dbl = dbl - {1'b0, p};
        end
        acc = dbl;
        if (b_q[N-1]) begin
            acc = dbl + {1'b0, a_q};
            if (acc >= {1'b0, p}) begin
                acc = acc - {1'b0, p};
            end
        end

        if (go) begin
            r_d   = '0;
            a_d   = a;
            b_d   = b;
            cnt_d = CW'(N);
        end else if (cnt_q != '0) begin
            r_d   = acc[N-1:0];
            b_d   = {b_q[N-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign r   = r_q;
    assign rdy = (cnt_q == CW'(1));

endmodule

// File: rtl/point_on_curve_check.sv
// Verifies y^2 == x^3 + a*x + b (mod p) for an affine point, using one shared serial multiplier.
// state     | meaning
// IDLE      | waiting for start (ignored on the first edge after reset release)
// CHECK     | infinity / range screening of the captured point
// MUL_XX    | t = x*x
// ADD_A     | t = t + a, launch t*x
// MUL_TX    | t = t*x
// ADD_B     | t = t + b, launch y*y
// MUL_YY    | s = y*y
// CMP       | on_curve = (s == t)
// DONE      | done pulse
module point_on_curve_check
    import ecc_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input logic clk,
    input logic reset,
    point_on_curve_check_if.slave bus
);

    state_t       state_q, state_d;
    logic         armed_q, armed_d;
    logic [N-1:0] p_q, p_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] y_q, y_d;
    logic         inf_q, inf_d;
    logic [N-1:0] t_q, t_d;
    logic         on_curve_q, on_curve_d;
    logic         range_err_q, range_err_d;

    logic         mul_go;
    logic [N-1:0] mul_a;
    logic [N-1:0] mul_b;
    logic [N-1:0] mul_r;
    logic         mul_rdy;
    logic [N-1:0] add_v;
    logic [N-1:0] add_sum;

    mod_mult_serial #(.N(N)) u_mult (
        .clk   (clk),
        .reset (reset),
        .go    (mul_go),
        .a     (mul_a),
        .b     (mul_b),
        .p     (p_q),
        .r     (mul_r),
        .rdy   (mul_rdy)
    );

    // One adder serves both ADD_A and ADD_B; the multiplier result is the left operand in each.
    assign add_v   = (state_q == ST_ADD_A) ? a_q : b_q;
    assign add_sum = N'(mod_add(N_DEFAULT'(mul_r), N_DEFAULT'(add_v), N_DEFAULT'(p_q)));

    always_comb begin
        state_d     = state_q;
        armed_d     = 1'b1;
        p_d         = p_q;
        a_d         = a_q;
        b_d         = b_q;
        x_d         = x_q;
        y_d         = y_q;
        inf_d       = inf_q;
        t_d         = t_q;
        on_curve_d  = on_curve_q;
        range_err_d = range_err_q;
        mul_go      = 1'b0;
        mul_a       = '0;
        mul_b       = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && armed_q) begin
                    p_d         = bus.p;
                    a_d         = bus.a;
                    b_d         = bus.b;
                    x_d         = bus.x;
                    y_d         = bus.y;
                    inf_d       = bus.infinity;
                    on_curve_d  = 1'b0;
                    range_err_d = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (inf_q) begin
                    on_curve_d = 1'b1;
                    state_d    = ST_DONE;
                end else if ((x_q >= p_q) || (y_q >= p_q)) begin
                    range_err_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    mul_go  = 1'b1;
                    mul_a   = x_q;
                    mul_b   = x_q;
                    state_d = ST_MUL_XX;
                end
            end
            ST_MUL_XX: begin
                if (mul_rdy) state_d = ST_ADD_A;
            end
            ST_ADD_A: begin
                t_d     = add_sum;
                mul_go  = 1'b1;
                mul_a   = add_sum;
                mul_b   = x_q;
                state_d = ST_MUL_TX;
            end
            ST_MUL_TX: begin
                if (mul_rdy) state_d = ST_ADD_B;
            end
            ST_ADD_B: begin
                t_d     = add_sum;
                mul_go  = 1'b1;
                mul_a   = y_q;
                mul_b   = y_q;
                state_d = ST_MUL_YY;
            end
            ST_MUL_YY: begin
                if (mul_rdy) state_d = ST_CMP;
            end
            ST_CMP: begin
                on_curve_d = (mul_r == t_q);
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            p_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            inf_q       <= 1'b0;
            t_q         <= '0;
            on_curve_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            p_q         <= p_d;
            a_q         <= a_d;
            b_q         <= b_d;
            x_q         <= x_d;
            y_q         <= y_d;
            inf_q       <= inf_d;
            t_q         <= t_d;
            on_curve_q  <= on_curve_d;
            range_err_q <= range_err_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.on_curve  = on_curve_q;
    assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_point_on_curve_check.sv
// Bench for point_on_curve_check at N=8: vector table through a done-driven scoreboard, plus
// hand sequences for start-while-busy, reset mid-operation and start at reset release.
module tb_point_on_curve_check;

    localparam int N        = 8;
    localparam int LAT_FULL = 3 * N + 5;
    localparam int LAT_FAST = 2;

    typedef struct {
        logic [N-1:0] p;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         inf;
        logic         exp_on;
        logic         exp_re;
        int           lat;
    } vec_t;

    typedef struct {
        logic on;
        logic re;
        int   start_cyc;
        int   lat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    point_on_curve_check_if #(.N(N)) bus ();

    point_on_curve_check #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            check("done_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("on_curve", 32'(bus.on_curve), 32'(mon_e.on));
                check("range_err", 32'(bus.range_err), 32'(mon_e.re));
                check("latency", cyc - mon_e.start_cyc, mon_e.lat);
            end
        end
    end

    task automatic add_vec(input int p, input int a, input int b, input int x, input int y,
                           input logic inf, input logic on, input logic re, input int lat);
        vec_t v;
        v.p = N'(p); v.a = N'(a); v.b = N'(b); v.x = N'(x); v.y = N'(y);
        v.inf = inf; v.exp_on = on; v.exp_re = re; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.p        = v.p;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.x        = v.x;
        bus.y        = v.y;
        bus.infinity = v.inf;
        bus.start    = 1'b1;
    endtask

    task automatic scramble();
        bus.p        = N'($urandom);
        bus.a        = N'($urandom);
        bus.b        = N'($urandom);
        bus.x        = N'($urandom);
        bus.y        = N'($urandom);
        bus.infinity = ~bus.infinity;
    endtask

    task automatic run_vec(input vec_t v);
        logic busy_ok;
        @(posedge clk); #1;
        drive(v);
        sb.push_back('{v.exp_on, v.exp_re, cyc, v.lat});
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        busy_ok = 1'b1;
        for (int k = 1; k <= v.lat + 1; k++) begin
            @(negedge clk);
            if (bus.busy !== (k <= v.lat)) busy_ok = 1'b0;
        end
        check("busy_window", 32'(busy_ok), 1);
        check("held_on_curve", 32'(bus.on_curve), 32'(v.exp_on));
        check("held_range_err", 32'(bus.range_err), 32'(v.exp_re));
        check("pending_results", sb.size(), 0);
        sb.delete();
    endtask

    function automatic vec_t mk(input int x, input int y, input logic on);
        vec_t v;
        v.p = 8'd23; v.a = 8'd1; v.b = 8'd1; v.x = N'(x); v.y = N'(y);
        v.inf = 1'b0; v.exp_on = on; v.exp_re = 1'b0; v.lat = LAT_FULL;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0;
        logic busy_seen;
        vec_t v;

        bus.start = 1'b0; bus.p = '0; bus.a = '0; bus.b = '0;
        bus.x = '0; bus.y = '0; bus.infinity = 1'b0;

        // p, a, b, x, y, inf, on_curve, range_err, latency
        add_vec(23, 1, 1,   3,  10, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,   3,  11, 1'b0, 1'b0, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,  23,   5, 1'b0, 1'b0, 1'b1, LAT_FAST);
        add_vec(23, 1, 1, 255, 255, 1'b1, 1'b1, 1'b0, LAT_FAST);
        add_vec(23, 1, 1,   0,   1, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,   0,  22, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,   4,   0, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,   4,   1, 1'b0, 1'b0, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,   5,  23, 1'b0, 1'b0, 1'b1, LAT_FAST);
        add_vec(23, 1, 1,  22,  22, 1'b0, 1'b0, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,   1,   7, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(23, 1, 1,  13,   7, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(23, 1, 0,   0,   0, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(97, 2, 3,   3,   6, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(97, 2, 3,   3,  91, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(97, 2, 3,   3,   7, 1'b0, 1'b0, 1'b0, LAT_FULL);
        add_vec(251, 5, 7,   2,   5, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(251, 5, 7,   2, 246, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(251, 5, 7, 250,   1, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(251, 5, 7, 250, 250, 1'b0, 1'b1, 1'b0, LAT_FULL);
        add_vec(251, 5, 7, 250,   2, 1'b0, 1'b0, 1'b0, LAT_FULL);
        add_vec(251, 5, 7, 251,   0, 1'b0, 1'b0, 1'b1, LAT_FAST);

        @(negedge clk);
        check("reset_state", {28'b0, bus.busy, bus.done, bus.on_curve, bus.range_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Second start while busy must be dropped, not queued.
        d0 = done_cnt;
        @(posedge clk); #1;
        drive(mk(3, 10, 1'b1));
        sb.push_back('{1'b1, 1'b0, cyc, LAT_FULL});
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            bus.start = (k == 10);
            if (k == 10) begin
                bus.x = 8'd3;
                bus.y = 8'd11;
            end
        end
        check("busy_start_on_curve", 32'(bus.on_curve), 1);
        check("busy_start_done_count", done_cnt - d0, 1);
        check("busy_start_pending", sb.size(), 0);
        sb.delete();

        // Reset clears a held verdict; a start at the first edge after release is ignored.
        @(posedge clk); #1;
        reset = 1'b1;
        drive(mk(3, 10, 1'b1));
        @(negedge clk);
        check("reset_clears_outputs", {28'b0, bus.busy, bus.done, bus.on_curve, bus.range_err}, 0);
        #1;
        reset = 1'b0;
        d0 = done_cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_seen = 1'b0;
        repeat (35) begin
            @(negedge clk);
            busy_seen |= bus.busy;
        end
        check("start_at_release_busy", 32'(busy_seen), 0);
        check("start_at_release_done", done_cnt - d0, 0);

        // Reset in cycle 15 of a request aborts it with no done pulse.
        @(posedge clk); #1;
        drive(mk(3, 10, 1'b1));
        sb.push_back('{1'b1, 1'b0, cyc, LAT_FULL});
        d0 = done_cnt;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (k == 14) begin
                @(negedge clk);
                check("busy_before_reset", 32'(bus.busy), 1);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {28'b0, bus.busy, bus.done, bus.on_curve, bus.range_err}, 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        v = mk(3, 11, 1'b0);
        run_vec(v);
        check("after_reset_done_count", done_cnt - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/point_on_curve_check.md
Name: point_on_curve_check

Overview:
- Checks that an affine point (x, y) satisfies y^2 = x^3 + a*x + b (mod p).
- Sits downstream of the scalar-multiplication engine, on the receive side of its (x3, y3) output. It also validates externally supplied base points before they enter the double-and-add datapath.
- Arithmetic is bit-serial: one shared interleaved modular multiplier, driven by a small FSM.

Parameters:
- n, 231, operand width in bits. It covers p, a, b, x and y.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high. Returns the block to IDLE and clears all outputs.
- start  input  1  request pulse. Sampled only in IDLE.
- p  input  n  field prime. Must be odd and greater than 2.
- a  input  n  curve coefficient a. Must be less than p.
- b  input  n  curve coefficient b. Must be less than p.
- x  input  n  point x coordinate.
- y  input  n  point y coordinate.
- infinity  input  1  the point is the point at infinity; x and y are ignored.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the result is valid.
- on_curve  output  1  verdict. Held until the next accepted start or reset.
- range_err  output  1  x >= p or y >= p. Held like on_curve.

Behaviour:
- Reset values: busy=0, done=0, on_curve=0, range_err=0; FSM in IDLE; all internal registers 0.
- Operand capture: on an accepted start (start=1 in IDLE), p, a, b, x, y and infinity are captured into registers. Inputs may change afterwards.
- start is ignored while busy. It is not queued.
- On acceptance, on_curve and range_err clear to 0.
- FSM states, in order:
  - IDLE
  - CHECK (1 cycle)
  - MUL_XX (n cycles)
  - ADD_A (1 cycle)
  - MUL_TX (n cycles)
  - ADD_B (1 cycle)
  - MUL_YY (n cycles)
  - CMP (1 cycle)
  - DONE (1 cycle, done=1)
  - back to IDLE
- CHECK:
  - If infinity=1: go to DONE with on_curve=1 and range_err=0.
  - Else if x >= p or y >= p: go to DONE with range_err=1 and on_curve=0.
  - Otherwise: go to MUL_XX.
- MUL_XX computes t = x*x mod p.
- ADD_A computes t = (t + a) mod p.
- MUL_TX computes t = t*x mod p.
- ADD_B computes t = (t + b) mod p.
- MUL_YY computes s = y*y mod p.
- CMP sets on_curve = (s == t).
- Modular multiply, R = A*B mod p. Scan B MSB-first, one bit per cycle:
  - r = 2r; if r >= p then r = r - p.
  - If the bit is 1: r = r + A; if r >= p then r = r - p.
  - Intermediates are n+1 bits wide. The multiplier starts with r = 0.
- Modular add: sum = u + v, n+1 bits wide; subtract p once if sum >= p.
- Latency, counting the cycle start is sampled as cycle 0:
  - Normal path: done is high in cycle 3n+5.
  - Infinity or range-error path: done is high in cycle 2.
- busy=1 in every cycle from 1 up to and including the DONE cycle.
- Reset mid-operation: asynchronous return to IDLE, outputs cleared, no done pulse.
- start asserted in the same cycle reset deasserts: ignored.
- Degenerate points: a point with x=0 or y=0 is evaluated normally. y=0 is a valid 2-torsion point if it satisfies the equation.

Decomposition:
- Shared package ecc_pkg holds:
  - the FSM state enum;
  - the default width constant N_DEFAULT = 231;
  - a mod_add function (n+1-bit sum, conditional subtract), reused by point_addition and point_doubling.
- Sub-module mod_mult_serial #(n) handles the interleaved multiply:
  - inputs: clk, reset, go, A, B, p;
  - outputs: r, rdy.
  - rdy is asserted n cycles after go.
  - The top FSM sequences three invocations.

Test Plan:
- n=8, p=23, a=1, b=1, point (3,10), infinity=0 -> y^2 = 8, rhs = 31 mod 23 = 8 -> on_curve=1, range_err=0, done in cycle 29.
- Same curve, point (3,11) -> y^2 = 121 mod 23 = 6 ≠ 8 -> on_curve=0, range_err=0, done in cycle 29.
- Same curve, x=23, y=5 -> range_err=1, on_curve=0, done in cycle 2, busy high only in cycles 1–2.
- Same curve, infinity=1 with x=y=0xFF -> on_curve=1, range_err=0, done in cycle 2.
- Start (3,10); pulse start again in cycle 10 with (3,11) -> second start ignored; on_curve=1 in cycle 29; no second done pulse.
- Start (3,10); assert reset in cycle 15 for 1 cycle, then start (3,11) -> no done for the first request; second request reports on_curve=0 29 cycles after its start; outputs read 0 while reset is high.
